// File: rtl/soc_bus_pkg.sv
// Shared types and helpers for the picorv32 memory bus fabric.
package soc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } bus_state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hdeadbeef;
    localparam int unsigned CNT_W             = 16;

    // Index width for n targets; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mem_bus_fabric_if.sv
// picorv32 native memory request/response bundle between the CPU and the fabric.
interface mem_bus_fabric_if;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_bus_decode.sv
// Combinational top-byte address decoder; the lowest-index matching target wins.
module mem_bus_decode
    import soc_bus_pkg::*;
#(
    parameter int unsigned                 NUM_SLAVES = 5,
    parameter logic [8*NUM_SLAVES-1:0]     SLAVE_BASE = {8'hff, 8'hfe, 8'hf0, 8'h01, 8'h00},
    parameter logic [8*NUM_SLAVES-1:0]     SLAVE_MASK = {NUM_SLAVES{8'hff}},
    localparam int unsigned                IDX_W      = clog2(NUM_SLAVES)
) (
    input  logic [7:0]       addr_hi,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((addr_hi & SLAVE_MASK[i*8 +: 8]) == SLAVE_BASE[i*8 +: 8])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_fabric.sv
// Single-master fabric: decode, wait-state/external acknowledge, read mux and sticky error status.
module mem_bus_fabric
    import soc_bus_pkg::*;
#(
    parameter int unsigned             NUM_SLAVES     = 5,
    parameter logic [8*NUM_SLAVES-1:0] SLAVE_BASE     = {8'hff, 8'hfe, 8'hf0, 8'h01, 8'h00},
    parameter logic [8*NUM_SLAVES-1:0] SLAVE_MASK     = {NUM_SLAVES{8'hff}},
    parameter logic [NUM_SLAVES-1:0]   ACK_EXT        = 5'b00001,
    parameter logic [4*NUM_SLAVES-1:0] WAIT_CYCLES    = {NUM_SLAVES{4'd0}},
    parameter int unsigned             TIMEOUT_CYCLES = 1024,
    parameter logic [31:0]             ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                     clk_cpu,
    input  logic                     reset,
    mem_bus_fabric_if.slave          cpu,
    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic [4*NUM_SLAVES-1:0]  s_wstrb,
    output logic [23:0]              s_addr,
    output logic [31:0]              s_wdata,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic                     err_clr,
    output logic                     err_unmapped,
    output logic                     err_timeout,
    output logic [31:0]              err_addr
);

    localparam int unsigned      IDX_W   = clog2(NUM_SLAVES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    bus_state_t        state, state_nxt;
    logic [IDX_W-1:0]  sel;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       rdata_q;
    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic              complete;
    logic              time_err;

    mem_bus_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .addr_hi (cpu.mem_addr[31:24]),
        .hit     (dec_hit),
        .idx     (dec_idx)
    );

    assign cpu.mem_ready = (state == DONE);
    assign cpu.mem_rdata = rdata_q;
    assign s_addr        = req_addr[23:0];
    assign s_wdata       = req_wdata;

    always_comb begin
        state_nxt = state;
        s_valid   = '0;
        s_wstrb   = '0;
        complete  = 1'b0;
        time_err  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu.mem_valid) state_nxt = dec_hit ? ACCESS : DONE;
            end
            ACCESS: begin
                s_valid[sel] = 1'b1;
                if (ACK_EXT[sel]) begin
                    // External ack beats a timeout landing on the same cycle.
                    s_wstrb[sel*4 +: 4] = req_wstrb;
                    if (s_ready[sel]) begin
                        complete = 1'b1;
                    end else if (cnt == TO_LAST) begin
                        complete = 1'b1;
                        time_err = 1'b1;
                    end
                end else begin
                    if (cnt == '0) s_wstrb[sel*4 +: 4] = req_wstrb;
                    if (cnt == {{(CNT_W-4){1'b0}}, WAIT_CYCLES[sel*4 +: 4]}) complete = 1'b1;
                end
                if (complete) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state        <= IDLE;
            sel          <= '0;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_wstrb    <= '0;
            cnt          <= '0;
            rdata_q      <= '0;
            err_unmapped <= 1'b0;
            err_timeout  <= 1'b0;
            err_addr     <= '0;
        end else begin
            state <= state_nxt;
            // Clear first so a coincident new error below takes precedence.
            if (err_clr) begin
                err_unmapped <= 1'b0;
                err_timeout  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cpu.mem_valid) begin
                        if (dec_hit) begin
                            sel       <= dec_idx;
                            req_addr  <= cpu.mem_addr;
                            req_wdata <= cpu.mem_wdata;
                            req_wstrb <= cpu.mem_wstrb;
                            cnt       <= '0;
                        end else begin
                            rdata_q      <= ERR_RDATA;
                            err_unmapped <= 1'b1;
                            err_addr     <= cpu.mem_addr;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != '1) cnt <= cnt + 1'b1;
                    if (complete) begin
                        if (time_err) begin
                            rdata_q     <= ERR_RDATA;
                            err_timeout <= 1'b1;
                            err_addr    <= req_addr;
                        end else begin
                            rdata_q <= s_rdata[sel*32 +: 32];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed bench for mem_bus_fabric: five targets, slave 1 with one wait state, 16-cycle timeout.
module tb_mem_bus_fabric;

    logic         clk_cpu;
    logic         reset;
    logic [4:0]   s_valid;
    logic [19:0]  s_wstrb;
    logic [23:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [159:0] s_rdata;
    logic [4:0]   s_ready;
    logic         err_clr;
    logic         err_unmapped;
    logic         err_timeout;
    logic [31:0]  err_addr;

    int n_pass  = 0;
    int n_total = 0;
    int early;

    mem_bus_fabric_if bus ();

    mem_bus_fabric #(
        .NUM_SLAVES     (5),
        .WAIT_CYCLES    ({4'd0, 4'd0, 4'd0, 4'd1, 4'd0}),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_cpu      (clk_cpu),
        .reset        (reset),
        .cpu          (bus),
        .s_valid      (s_valid),
        .s_wstrb      (s_wstrb),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_rdata      (s_rdata),
        .s_ready      (s_ready),
        .err_clr      (err_clr),
        .err_unmapped (err_unmapped),
        .err_timeout  (err_timeout),
        .err_addr     (err_addr)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic request(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wstrb = wstrb;
        bus.mem_wdata = wdata;
    endtask

    initial begin
        reset         = 1'b1;
        err_clr       = 1'b0;
        s_ready       = '0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        s_rdata       = {32'h44444444, 32'h33333333, 32'h22222222, 32'h12345678, 32'h0badf00d};
        tick(); tick(); tick();

        chk("rst_ready",    32'(bus.mem_ready), 32'd0);
        chk("rst_rdata",    bus.mem_rdata,      32'd0);
        chk("rst_svalid",   32'(s_valid),       32'd0);
        chk("rst_swstrb",   32'(s_wstrb),       32'd0);
        chk("rst_err_unm",  32'(err_unmapped),  32'd0);
        chk("rst_err_to",   32'(err_timeout),   32'd0);
        chk("rst_err_addr", err_addr,           32'd0);
        reset = 1'b0;
        tick();

        // Internal slave 1, one wait state: ACCESS on cycles 1-2, ready on cycle 3.
        request(32'h01000010, 4'b0000, 32'd0);
        tick();
        chk("rd1_c1_svalid", 32'(s_valid),       32'h02);
        chk("rd1_c1_ready",  32'(bus.mem_ready), 32'd0);
        chk("rd1_c1_saddr",  32'(s_addr),        32'h000010);
        tick();
        chk("rd1_c2_svalid", 32'(s_valid),       32'h02);
        chk("rd1_c2_ready",  32'(bus.mem_ready), 32'd0);
        tick();
        chk("rd1_c3_ready",  32'(bus.mem_ready), 32'd1);
        chk("rd1_c3_rdata",  bus.mem_rdata,      32'h12345678);
        chk("rd1_c3_svalid", 32'(s_valid),       32'd0);
        bus.mem_valid = 1'b0;
        tick();
        chk("rd1_idle_ready", 32'(bus.mem_ready), 32'd0);
        chk("rd1_rdata_hold", bus.mem_rdata,      32'h12345678);

        // 0xfe decodes to slave 3 (internal, no wait): one strobe cycle, ready on cycle 2.
        request(32'hfe000000, 4'b0001, 32'h0000003f);
        tick();
        chk("wr_c1_svalid", 32'(s_valid),       32'h08);
        chk("wr_c1_swstrb", 32'(s_wstrb),       32'h01000);
        chk("wr_c1_swdata", s_wdata,            32'h0000003f);
        chk("wr_c1_ready",  32'(bus.mem_ready), 32'd0);
        tick();
        chk("wr_c2_ready",  32'(bus.mem_ready), 32'd1);
        chk("wr_c2_swstrb", 32'(s_wstrb),       32'd0);
        bus.mem_valid = 1'b0;
        tick();

        // External slave 0 acks after a few cycles.
        request(32'h00000100, 4'b0000, 32'd0);
        tick();
        chk("ext_c1_svalid", 32'(s_valid), 32'h01);
        early = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.mem_ready) early++;
        end
        chk("ext_no_early_ready", 32'(early),    32'd0);
        chk("ext_c5_svalid",      32'(s_valid),  32'h01);
        s_ready = 5'b00001;
        tick();
        s_ready = '0;
        chk("ext_ready",   32'(bus.mem_ready), 32'd1);
        chk("ext_rdata",   bus.mem_rdata,      32'h0badf00d);
        chk("ext_err_to",  32'(err_timeout),   32'd0);
        chk("ext_err_unm", 32'(err_unmapped),  32'd0);
        bus.mem_valid = 1'b0;
        tick();

        // Timeout: 16 ACCESS cycles (cycles 1..16), error completion on cycle 17.
        request(32'h00000100, 4'b0000, 32'd0);
        tick();
        early = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.mem_ready) early++;
            tick();
        end
        chk("to_no_early_ready", 32'(early),   32'd0);
        chk("to_c16_svalid",     32'(s_valid), 32'h01);
        tick();
        chk("to_ready",    32'(bus.mem_ready), 32'd1);
        chk("to_rdata",    bus.mem_rdata,      32'hdeadbeef);
        chk("to_err_to",   32'(err_timeout),   32'd1);
        chk("to_err_addr", err_addr,           32'h00000100);
        chk("to_err_unm",  32'(err_unmapped),  32'd0);
        bus.mem_valid = 1'b0;
        tick();

        // Unmapped access completes on cycle 1.
        request(32'h80000000, 4'b0000, 32'd0);
        tick();
        chk("unm_ready",    32'(bus.mem_ready), 32'd1);
        chk("unm_rdata",    bus.mem_rdata,      32'hdeadbeef);
        chk("unm_err_unm",  32'(err_unmapped),  32'd1);
        chk("unm_err_addr", err_addr,           32'h80000000);
        chk("unm_svalid",   32'(s_valid),       32'd0);
        bus.mem_valid = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_err_unm",  32'(err_unmapped), 32'd0);
        chk("clr_err_to",   32'(err_timeout),  32'd0);
        chk("clr_err_addr", err_addr,          32'h80000000);

        // A new error on the same cycle as err_clr still sets the flag.
        request(32'h7f000000, 4'b0000, 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr       = 1'b0;
        bus.mem_valid = 1'b0;
        chk("clrset_err_unm",  32'(err_unmapped), 32'd1);
        chk("clrset_err_addr", err_addr,          32'h7f000000);
        tick();

        // Reset in the middle of an external access aborts it.
        request(32'h00000200, 4'b0000, 32'd0);
        tick();
        chk("rstmid_c1_svalid", 32'(s_valid), 32'h01);
        tick();
        reset         = 1'b1;
        bus.mem_valid = 1'b0;
        tick();
        reset = 1'b0;
        chk("rstmid_svalid",  32'(s_valid),       32'd0);
        chk("rstmid_ready",   32'(bus.mem_ready), 32'd0);
        chk("rstmid_err_unm", 32'(err_unmapped),  32'd0);
        tick();
        chk("rstmid_idle_ready",  32'(bus.mem_ready), 32'd0);
        chk("rstmid_idle_svalid", 32'(s_valid),       32'd0);

        s_rdata[63:32] = 32'hcafef00d;
        request(32'h01000020, 4'b0000, 32'd0);
        tick();
        chk("post_c1_svalid", 32'(s_valid), 32'h02);
        tick();
        chk("post_c2_ready", 32'(bus.mem_ready), 32'd0);
        tick();
        chk("post_c3_ready", 32'(bus.mem_ready), 32'd1);
        chk("post_c3_rdata", bus.mem_rdata,      32'hcafef00d);
        bus.mem_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
